// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - pipeline register chain with central stall/flush resolution
// Bubbles are inserted just below the deepest stall point; flush beats stall, freeze beats everything.
module pipe_stage_chain #(
  parameter int NSTAGE        = 4,
  parameter int W             = 64,
  parameter bit CLEAR_PAYLOAD = 1'b1,
  parameter int CNT_W         = 16,
  localparam int OCC_W        = $clog2(NSTAGE + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                freeze_i,
  input  logic [NSTAGE-1:0]   stall_i,
  input  logic [NSTAGE-1:0]   flush_i,
  input  logic [NSTAGE*W-1:0] stage_n_i,
  input  logic [NSTAGE-1:0]   stage_vld_n_i,
  output logic [NSTAGE*W-1:0] stage_o,
  output logic [NSTAGE-1:0]   stage_vld_o,
  output logic [NSTAGE-1:0]   hold_o,
  output logic [OCC_W-1:0]    occupancy_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  // at_or_below[i]: some stall bit at index >= i, i.e. register i sits at or upstream of the deepest stall
  logic [NSTAGE-1:0] at_or_below;
  logic [NSTAGE-1:0] stall_bubble;
  logic [NSTAGE-1:0] bubble;
  logic              count_bubble;

  always_comb begin
    at_or_below  = '0;
    stall_bubble = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      at_or_below[i] = |(stall_i >> i);
    end
    for (int i = 1; i < NSTAGE; i++) begin
      stall_bubble[i] = at_or_below[i-1] & ~at_or_below[i];
    end
    bubble       = flush_i | stall_bubble;
    count_bubble = ~freeze_i & (|(stall_bubble & ~flush_i));
    hold_o       = {NSTAGE{freeze_i}} | (at_or_below & ~flush_i);
  end

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      occupancy_o = occupancy_o + OCC_W'(stage_vld_o[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stage_o      <= '0;
      stage_vld_o  <= '0;
      bubble_cnt_o <= '0;
    end else if (!freeze_i) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (bubble[i]) begin
          stage_vld_o[i] <= 1'b0;
          if (CLEAR_PAYLOAD) stage_o[i*W +: W] <= '0;
        end else if (!at_or_below[i]) begin
          stage_o[i*W +: W] <= stage_n_i[i*W +: W];
          stage_vld_o[i]    <= stage_vld_n_i[i];
        end
      end
      if (count_bubble && bubble_cnt_o != {CNT_W{1'b1}}) begin
        bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
      end
    end
  end

  a_ctrl_known: assert property (@(posedge CLK) disable iff (RST) !$isunknown({stall_i, flush_i}));

endmodule
